// File: rtl/request_slot_bank_pkg.sv
// Shared definitions for the request slot bank.
// Contents: width helpers for slot indices and occupancy counts, and the request word type.
// The type matches an 8-bit floor request.
package request_slot_bank_pkg;

  localparam int unsigned ReqWidth = 8;

  typedef logic [ReqWidth-1:0] req_t;

  // Bits needed to index one of 'depth' slots.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/request_slot_bank_if.sv
// Bus bundle between the request encoder/scheduler side (master) and the slot bank (slave).
// Inputs to the bank:
//   load     write request
//   in       request word to store
//   clr      per-slot clear mask
//   ovf_clr  clears the sticky overflow flag
// Outputs from the bank:
//   out      flattened slot data, slot k at out[k*WIDTH +: WIDTH]
//   valid    slot occupied flags
//   count    number of occupied slots
//   full     all slots occupied
//   empty    no slot occupied
//   accept   registered pulse for a stored or already-pending load
//   overflow sticky flag for a dropped load
interface request_slot_bank_if
  import request_slot_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic                   load;
  logic [WIDTH-1:0]       in;
  logic [DEPTH-1:0]       clr;
  logic                   ovf_clr;
  logic [DEPTH*WIDTH-1:0] out;
  logic [DEPTH-1:0]       valid;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   overflow;

  modport master (
    output load, in, clr, ovf_clr,
    input  out, valid, count, full, empty, accept, overflow
  );

  modport slave (
    input  load, in, clr, ovf_clr,
    output out, valid, count, full, empty, accept, overflow
  );
endinterface

// File: rtl/request_slot_select.sv
// Lowest-index priority encoder over a free-slot mask.
// Ports:
//   free       1 = slot is available
//   grant      one-hot selection of the lowest free slot, zero if none free
//   none_free  no slot is available
module request_slot_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0] free,
  output logic [DEPTH-1:0] grant,
  output logic             none_free
);

  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (free[k] && !found) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
    none_free = ~found;
  end

endmodule

// File: rtl/request_slot_bank.sv
// Store for pending elevator requests: DEPTH slots of WIDTH bits, each with a valid flag.
// A load is written into the lowest-index free slot; slots are cleared individually.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      request_slot_bank_if slave modport (load/in/clr/ovf_clr in, status/data out)
// Optional build macro DUP_FILTER_EN: a load whose word matches any valid slot is not stored,
// is still acknowledged with accept, and never sets overflow.
module request_slot_bank
  import request_slot_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              reset_n,
  request_slot_bank_if.slave bus
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic                        accept_q, accept_d;
  logic                        overflow_q, overflow_d;

  logic [DEPTH-1:0] grant;
  logic             none_free;
  logic             dup_hit;
  logic             do_write;

  // Free-slot choice uses pre-edge valid, so a slot cleared this cycle is not eligible.
  request_slot_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .free      (~valid_q),
    .grant     (grant),
    .none_free (none_free)
  );

`ifdef DUP_FILTER_EN
  always_comb begin
    dup_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && (data_q[k] == bus.in)) dup_hit = 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  assign do_write = bus.load && !none_free && !dup_hit;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~bus.clr;
    for (int k = 0; k < DEPTH; k++) begin
      if (do_write && grant[k]) begin
        data_d[k]  = bus.in;
        valid_d[k] = 1'b1;
      end
    end
    // A pending duplicate counts as accepted.
    accept_d   = bus.load && (dup_hit || !none_free);
    overflow_d = overflow_q;
    if (bus.load && none_free && !dup_hit) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      valid_q    <= '0;
      accept_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      accept_q   <= accept_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CW'(valid_q[k]);
    end
    bus.count = cnt;
  end

  assign bus.out      = data_q;
  assign bus.valid    = valid_q;
  assign bus.full     = &valid_q;
  assign bus.empty    = ~|valid_q;
  assign bus.accept   = accept_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_request_slot_bank.sv
module tb_request_slot_bank;
  import request_slot_bank_pkg::*;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  request_slot_bank_if #(.WIDTH(8), .DEPTH(4)) bus ();

  request_slot_bank #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.load    = 1'b0;
    bus.in      = '0;
    bus.clr     = '0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    idle();
    #1 reset_n = 1'b0;
    #2;
    n_cmp++; if (bus.out !== 32'h0) begin n_bad++; $display("FAIL reset_out: got %h want %h", bus.out, 32'h0); end
    n_cmp++; if (bus.valid !== 4'b0000) begin n_bad++; $display("FAIL reset_valid: got %b want %b", bus.valid, 4'b0000); end
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want %0d", bus.count, 0); end
    n_cmp++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_empty_full: got %b%b want 10", bus.empty, bus.full); end
    n_cmp++; if (bus.accept !== 1'b0 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", bus.accept, bus.overflow); end
    step();
    #2 reset_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    req_t       words [4];
    logic [3:0] exp_valid [4];
    words     = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_valid = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      bus.load = 1'b1;
      bus.in   = words[i];
      step();
      n_cmp++; if (bus.accept !== 1'b1) begin n_bad++; $display("FAIL fill_accept[%0d]: got %b want 1", i, bus.accept); end
      n_cmp++; if (bus.valid !== exp_valid[i]) begin n_bad++; $display("FAIL fill_valid[%0d]: got %b want %b", i, bus.valid, exp_valid[i]); end
    end
    idle();
    step();
    n_cmp++; if (bus.out !== 32'h44332211) begin n_bad++; $display("FAIL fill_out: got %h want %h", bus.out, 32'h44332211); end
    n_cmp++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_full_count: got %b/%0d want 1/4", bus.full, bus.count); end
    n_cmp++; if (bus.accept !== 1'b0) begin n_bad++; $display("FAIL fill_accept_idle: got %b want 0", bus.accept); end
  endtask

  task automatic test_overflow();
    bus.load = 1'b1;
    bus.in   = 8'h55;
    step();
    idle();
    n_cmp++; if (bus.accept !== 1'b0 || bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got acc=%b ovf=%b want 0/1", bus.accept, bus.overflow); end
    n_cmp++; if (bus.out !== 32'h44332211 || bus.valid !== 4'b1111) begin n_bad++; $display("FAIL ovf_nochange: got %h/%b want 44332211/1111", bus.out, bus.valid); end
    step();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    bus.ovf_clr = 1'b1;
    step();
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    // Set wins over a simultaneous clear.
    bus.load = 1'b1;
    bus.in   = 8'h56;
    step();
    idle();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: got %b want 1", bus.overflow); end
    bus.ovf_clr = 1'b1;
    step();
    idle();
  endtask

  task automatic test_clr_load();
    bus.clr  = 4'b0100;
    bus.load = 1'b1;
    bus.in   = 8'h66;
    step();
    idle();
    n_cmp++; if (bus.valid !== 4'b1011) begin n_bad++; $display("FAIL clrload_valid: got %b want 1011", bus.valid); end
    n_cmp++; if (bus.overflow !== 1'b1 || bus.accept !== 1'b0) begin n_bad++; $display("FAIL clrload_flags: got ovf=%b acc=%b want 1/0", bus.overflow, bus.accept); end
    n_cmp++; if (bus.out[23:16] !== 8'h33) begin n_bad++; $display("FAIL clrload_drop: got %h want 33", bus.out[23:16]); end
    bus.load = 1'b1;
    bus.in   = 8'h77;
    step();
    idle();
    n_cmp++; if (bus.out !== 32'h44772211 || bus.valid !== 4'b1111) begin n_bad++; $display("FAIL clrload_refill: got %h/%b want 44772211/1111", bus.out, bus.valid); end
    n_cmp++; if (bus.accept !== 1'b1) begin n_bad++; $display("FAIL clrload_accept: got %b want 1", bus.accept); end
    bus.ovf_clr = 1'b1;
    step();
    idle();
  endtask

  task automatic test_lowest_free();
    bus.clr = 4'b0101;
    step();
    idle();
    n_cmp++; if (bus.valid !== 4'b1010 || bus.count !== 3'd2) begin n_bad++; $display("FAIL lf_clr: got %b/%0d want 1010/2", bus.valid, bus.count); end
    bus.load = 1'b1;
    bus.in   = 8'h09;
    step();
    idle();
    n_cmp++; if (bus.out[7:0] !== 8'h09 || bus.valid !== 4'b1011) begin n_bad++; $display("FAIL lf_slot0: got %h/%b want 09/1011", bus.out[7:0], bus.valid); end
    bus.clr = 4'b1111;
    step();
    idle();
    n_cmp++; if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.valid !== 4'b0000) begin n_bad++; $display("FAIL lf_empty: got e=%b c=%0d v=%b want 1/0/0000", bus.empty, bus.count, bus.valid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      bus.load = 1'b1;
      bus.in   = 8'hA0 + 8'(i);
      step();
    end
    idle();
    bus.clr = 4'b0001;
    step();
    bus.clr  = '0;
    bus.load = 1'b1;
    bus.in   = 8'hAB;
    step();
    idle();
    n_cmp++; if (bus.accept !== 1'b1 || bus.overflow !== 1'b1 || bus.valid !== 4'b1111) begin n_bad++; $display("FAIL ar_pre: got acc=%b ovf=%b v=%b want 1/1/1111", bus.accept, bus.overflow, bus.valid); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.valid !== 4'b0000 || bus.accept !== 1'b0 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ar_now: got v=%b acc=%b ovf=%b want 0000/0/0", bus.valid, bus.accept, bus.overflow); end
    n_cmp++; if (bus.out !== 32'h0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL ar_data: got %h e=%b want 0/1", bus.out, bus.empty); end
    step();
    #2 reset_n = 1'b1;
    step();
    n_cmp++; if (bus.accept !== 1'b0 || bus.valid !== 4'b0000) begin n_bad++; $display("FAIL ar_after: got acc=%b v=%b want 0/0000", bus.accept, bus.valid); end
  endtask

  task automatic test_dup();
    req_t words [2];
    words = '{8'h11, 8'h22};
    for (int i = 0; i < 2; i++) begin
      bus.load = 1'b1;
      bus.in   = words[i];
      step();
    end
    bus.in = 8'h22;
    step();
    idle();
    n_cmp++; if (bus.accept !== 1'b1) begin n_bad++; $display("FAIL dup_accept: got %b want 1", bus.accept); end
`ifdef DUP_FILTER_EN
    n_cmp++; if (bus.valid !== 4'b0011 || bus.count !== 3'd2) begin n_bad++; $display("FAIL dup_filtered: got %b/%0d want 0011/2", bus.valid, bus.count); end
`else
    n_cmp++; if (bus.valid !== 4'b0111 || bus.count !== 3'd3 || bus.out[23:16] !== 8'h22) begin n_bad++; $display("FAIL dup_stored: got %b/%0d/%h want 0111/3/22", bus.valid, bus.count, bus.out[23:16]); end
`endif
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL dup_ovf: got %b want 0", bus.overflow); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_clr_load();
    test_lowest_free();
    test_async_reset();
    test_dup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
